// File: rtl/cmp_operand_loader.sv
// Serial operand loader for a 4-bit magnitude comparator: assembles A/B from a
// bit stream, holds them on the comparator inputs, then captures and tallies the verdict.
module cmp_operand_loader #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear_cnt,
  output logic             a0,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             b0,
  output logic             b1,
  output logic             b2,
  output logic             b3,
  output logic             op_valid,
  input  logic             a_bigger_in,
  input  logic             b_bigger_in,
  input  logic             equals_in,
  output logic             res_valid,
  output logic             res_a,
  output logic             res_b,
  output logic             res_eq,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_eq,
  output logic             err
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE} state_t;

  state_t     state, state_nxt;
  logic [1:0] bit_cnt;
  logic [3:0] sh_a, sh_b;
  logic [3:0] a_q, b_q;
  logic [3:0] settle_cnt;
  logic       accept, last_bit, capture, verdict_ok;

  assign bit_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign accept     = bit_valid && bit_ready;
  assign last_bit   = accept && (bit_cnt == 2'd3);
  assign capture    = (state == SETTLE) && (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign verdict_ok = $onehot({a_bigger_in, b_bigger_in, equals_in});

  assign {a3, a2, a1, a0} = a_q;
  assign {b3, b2, b1, b0} = b_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (last_bit) state_nxt = LOAD_B;
      LOAD_B:  if (last_bit) state_nxt = SETTLE;
      SETTLE:  if (capture)  state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      settle_cnt <= '0;
      op_valid   <= 1'b0;
      res_valid  <= 1'b0;
      res_a      <= 1'b0;
      res_b      <= 1'b0;
      res_eq     <= 1'b0;
    end else begin
      res_valid <= capture;
      if (accept) begin
        bit_cnt <= bit_cnt + 2'd1;
        if (state == LOAD_A) sh_a[bit_cnt] <= bit_in;
        else                 sh_b[bit_cnt] <= bit_in;
      end
      // Outputs are shadowed: they only move when a complete pair is ready.
      if (state == LOAD_B && last_bit) begin
        a_q        <= sh_a;
        b_q        <= {bit_in, sh_b[2:0]};
        op_valid   <= 1'b1;
        settle_cnt <= '0;
      end
      if (state == SETTLE) begin
        if (capture) begin
          res_a      <= a_bigger_in;
          res_b      <= b_bigger_in;
          res_eq     <= equals_in;
          op_valid   <= 1'b0;
          settle_cnt <= '0;
        end else begin
          settle_cnt <= settle_cnt + 4'd1;
        end
      end
    end
  end

  // Clear has priority over a coincident capture.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      cnt_a  <= '0;
      cnt_b  <= '0;
      cnt_eq <= '0;
      err    <= 1'b0;
    end else if (capture) begin
      if (!verdict_ok)                       err    <= 1'b1;
      else if (a_bigger_in && cnt_a  != '1)  cnt_a  <= cnt_a  + CNT_W'(1);
      else if (b_bigger_in && cnt_b  != '1)  cnt_b  <= cnt_b  + CNT_W'(1);
      else if (equals_in   && cnt_eq != '1)  cnt_eq <= cnt_eq + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Directed bench for cmp_operand_loader with a behavioural comparator attached
// and a scoreboard of expected verdicts; a second instance uses 2-bit tallies.
module tb_cmp_operand_loader;

  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, clear_cnt;
  logic a_bigger_in, b_bigger_in, equals_in;
  logic bit_ready, a0, a1, a2, a3, b0, b1, b2, b3, op_valid;
  logic res_valid, res_a, res_b, res_eq, err;
  logic [7:0] cnt_a, cnt_b, cnt_eq;

  logic d2_bit_ready, d2_a0, d2_a1, d2_a2, d2_a3, d2_b0, d2_b1, d2_b2, d2_b3;
  logic d2_op_valid, d2_res_valid, d2_res_a, d2_res_b, d2_res_eq, d2_err;
  logic [1:0] d2_cnt_a, d2_cnt_b, d2_cnt_eq;

  logic inject = 1'b0;
  logic [3:0] a_vec, b_vec;

  typedef struct packed {logic ra; logic rb; logic req;} exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int m_a, m_b, m_eq, m_err;
  logic [3:0] last_a, last_b;

  always #5 clk = ~clk;

  assign a_vec = {a3, a2, a1, a0};
  assign b_vec = {b3, b2, b1, b0};
  assign a_bigger_in = inject ? 1'b1 : (a_vec > b_vec);
  assign b_bigger_in = inject ? 1'b1 : (b_vec > a_vec);
  assign equals_in   = inject ? 1'b0 : (a_vec == b_vec);

  cmp_operand_loader #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .clear_cnt(clear_cnt), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .op_valid(op_valid),
    .a_bigger_in(a_bigger_in), .b_bigger_in(b_bigger_in), .equals_in(equals_in),
    .res_valid(res_valid), .res_a(res_a), .res_b(res_b), .res_eq(res_eq),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_eq(cnt_eq), .err(err));

  cmp_operand_loader #(.SETTLE_CYCLES(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(d2_bit_ready),
    .clear_cnt(clear_cnt), .a0(d2_a0), .a1(d2_a1), .a2(d2_a2), .a3(d2_a3),
    .b0(d2_b0), .b1(d2_b1), .b2(d2_b2), .b3(d2_b3), .op_valid(d2_op_valid),
    .a_bigger_in(a_bigger_in), .b_bigger_in(b_bigger_in), .equals_in(equals_in),
    .res_valid(d2_res_valid), .res_a(d2_res_a), .res_b(d2_res_b), .res_eq(d2_res_eq),
    .cnt_a(d2_cnt_a), .cnt_b(d2_cnt_b), .cnt_eq(d2_cnt_eq), .err(d2_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, " cnt_a"},  32'(cnt_a),  32'(sat(m_a, 255)));
    check({tag, " cnt_b"},  32'(cnt_b),  32'(sat(m_b, 255)));
    check({tag, " cnt_eq"}, 32'(cnt_eq), 32'(sat(m_eq, 255)));
    check({tag, " err"},    32'(err),    32'(m_err));
    check({tag, " cnt_a w2"}, 32'(d2_cnt_a), 32'(sat(m_a, 3)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b0; clear_cnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_a = 0; m_b = 0; m_eq = 0; m_err = 0;
    last_a = 4'h0; last_b = 4'h0;
    exp_q.delete();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_cnt = 1'b1;
    @(posedge clk);
    #1 clear_cnt = 1'b0;
    m_a = 0; m_b = 0; m_eq = 0; m_err = 0;
    check_counts("clear");
  endtask

  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input bit clr_cap);
    exp_t e;
    exp_t got;
    int lat;
    e.ra  = inject | (a > b);
    e.rb  = inject | (b > a);
    e.req = !inject && (a == b);
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in = (i < 4) ? a[i] : b[i-4];
      if (i == 5) begin
        check("shadow a", 32'(a_vec), 32'(last_a));
        check("shadow b", 32'(b_vec), 32'(last_b));
      end
      @(posedge clk);
      #1;
    end
    check("operand a", 32'(a_vec), 32'(a));
    check("operand b", 32'(b_vec), 32'(b));
    check("op_valid set", 32'(op_valid), 32'd1);
    // Random bits during settle must be refused.
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    clear_cnt = clr_cap;
    check("ready in settle", 32'(bit_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!res_valid && lat < 20);
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    check("latency", 32'(lat), 32'd1);
    check("op_valid clr", 32'(op_valid), 32'd0);
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("res_a",  32'(res_a),  32'(got.ra));
      check("res_b",  32'(res_b),  32'(got.rb));
      check("res_eq", 32'(res_eq), 32'(got.req));
    end
    if (clr_cap) begin
      m_a = 0; m_b = 0; m_eq = 0; m_err = 0;
    end else if (inject) begin
      m_err = 1;
    end else if (a > b) m_a++;
    else if (b > a)     m_b++;
    else                m_eq++;
    last_a = a; last_b = b;
    @(posedge clk);
    #1;
    check("res_valid pulse", 32'(res_valid), 32'd0);
    check_counts("pair");
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    @(posedge clk);
    #1;
    check("rst bit_ready", 32'(bit_ready), 32'd1);
    check("rst a", 32'(a_vec), 32'd0);
    check("rst b", 32'(b_vec), 32'd0);
    check("rst op_valid", 32'(op_valid), 32'd0);
    check("rst res", 32'({res_valid, res_a, res_b, res_eq}), 32'd0);
    check_counts("rst");

    send_pair(4'b1010, 4'b0011, 1'b0);

    do_clear();
    send_pair(4'd5, 4'd5, 1'b0);
    send_pair(4'd2, 4'd9, 1'b0);
    send_pair(4'd9, 4'd2, 1'b0);

    inject = 1'b1;
    send_pair(4'd7, 4'd1, 1'b0);
    inject = 1'b0;
    send_pair(4'd1, 4'd2, 1'b0);
    do_clear();

    for (int i = 0; i < 5; i++) send_pair(4'(i + 8), 4'(i), 1'b0);

    send_pair(4'd6, 4'd4, 1'b1);

    // Six stale bits, then reset, then a full pair.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in = 1'b1;
    end
    do_reset();
    send_pair(4'd3, 4'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
